// File: rtl/mci_pkg.sv
// ============================================================================
// Module  : mci_pkg
// Purpose : Shared MCI types and constants: boot sequencer state encoding,
//           MCU reset-request FSM state encoding and the default
//           acknowledge timeout for the reset-request controller.
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package mci_pkg;

    // Boot sequencer states as observed by blocks that follow the boot flow.
    typedef enum logic [3:0] {
        BOOT_IDLE                   = 4'd0,
        BOOT_OTP_FC                 = 4'd1,
        BOOT_WAIT_CPTRA_GO          = 4'd2,
        BOOT_WAIT_MCU_RST_REQ       = 4'd3,
        BOOT_RST_MCU                = 4'd4,
        BOOT_WAIT_CPTRA_MCU_RST_REQ = 4'd5,
        BOOT_BREAKPOINT             = 4'd6
    } mci_boot_fsm_state_e;

    // MCU reset-request handshake controller states.
    typedef enum logic [1:0] {
        REQ_IDLE   = 2'd0,
        REQ_ASSERT = 2'd1,
        REQ_IN_RST = 2'd2,
        REQ_DONE   = 2'd3
    } mci_rst_req_fsm_state_e;

    localparam logic [15:0] MCI_RST_REQ_TIMEOUT_DEFAULT = 16'hFFFF;

endpackage

`default_nettype wire

// File: rtl/mci_mcu_rst_req_ctrl.sv
// ============================================================================
// Module  : mci_mcu_rst_req_ctrl
// Purpose : Converts a CSR write pulse into a level MCU reset request for the
//           boot sequencer, follows the MCU through reset and release, and
//           reports completion, dropped requests and acknowledge timeouts.
// Ports   : clk, mci_rst_b            - clock, sync active-low reset
//           rst_req_wr, err_clr       - CSR pulses (request / clear error)
//           boot_fsm, mcu_rst_b       - sequencer state and MCU reset
//           fw_boot_upd_reset,
//           fw_hitless_upd_reset      - sequencer reset-type flags
//           mcu_rst_req               - level request to sequencer
//           rst_req_busy/done/drop    - status (done, drop are 1-cycle pulses)
//           rst_req_err               - sticky acknowledge-timeout flag
//           last_rst_hitless          - type of last acknowledged reset
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mci_mcu_rst_req_ctrl
    import mci_pkg::*;
#(
    parameter int unsigned           TIMEOUT_W = 16,
    parameter logic [TIMEOUT_W-1:0]  TIMEOUT   = TIMEOUT_W'(MCI_RST_REQ_TIMEOUT_DEFAULT)
) (
    input  logic                clk,
    input  logic                mci_rst_b,
    input  logic                rst_req_wr,
    input  logic                err_clr,
    input  mci_boot_fsm_state_e boot_fsm,
    input  logic                mcu_rst_b,
    input  logic                fw_boot_upd_reset,
    input  logic                fw_hitless_upd_reset,
    output logic                mcu_rst_req,
    output logic                rst_req_busy,
    output logic                rst_req_done,
    output logic                rst_req_drop,
    output logic                rst_req_err,
    output logic                last_rst_hitless
);

    localparam logic [TIMEOUT_W-1:0] c_timeout_last = TIMEOUT - TIMEOUT_W'(1);

    mci_rst_req_fsm_state_e r_state;
    mci_rst_req_fsm_state_e w_state_nxt;
    logic [TIMEOUT_W-1:0]   r_cnt;
    logic                   w_ack;
    logic                   w_timeout;
    logic                   w_err_set;
    logic                   w_drop_set;
    logic                   r_req;
    logic                   r_busy;
    logic                   r_done;
    logic                   r_drop;
    logic                   r_err;
    logic                   r_hitless;

    // The hitless flag alone identifies the reset type; the FW-boot flag is
    // its complement and carries no extra information here.
    logic                   w_unused;
    assign w_unused = fw_boot_upd_reset;

    // Counter value TIMEOUT-1 is the last ASSERT cycle, so the request is
    // visible for exactly TIMEOUT cycles before the error is raised.
    assign w_timeout  = (TIMEOUT != '0) && (r_cnt == c_timeout_last);
    assign w_drop_set = rst_req_wr && (r_state != REQ_IDLE);

    always_comb begin
        w_state_nxt = r_state;
        w_ack       = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            REQ_IDLE: begin
                if (rst_req_wr) begin
                    w_state_nxt = REQ_ASSERT;
                end
            end
            REQ_ASSERT: begin
                // Acknowledge has priority over a coincident timeout.
                if (boot_fsm == BOOT_RST_MCU) begin
                    w_state_nxt = REQ_IN_RST;
                    w_ack       = 1'b1;
                end else if (w_timeout) begin
                    w_state_nxt = REQ_IDLE;
                    w_err_set   = 1'b1;
                end
            end
            REQ_IN_RST: begin
                if ((boot_fsm != BOOT_RST_MCU) && mcu_rst_b) begin
                    w_state_nxt = REQ_DONE;
                end
            end
            REQ_DONE: begin
                w_state_nxt = REQ_IDLE;
            end
            default: begin
                w_state_nxt = REQ_IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they align with r_state.
    always_ff @(posedge clk) begin
        if (!mci_rst_b) begin
            r_state   <= REQ_IDLE;
            r_cnt     <= '0;
            r_req     <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_drop    <= 1'b0;
            r_err     <= 1'b0;
            r_hitless <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_req   <= (w_state_nxt == REQ_ASSERT);
            r_busy  <= (w_state_nxt != REQ_IDLE);
            r_done  <= (w_state_nxt == REQ_DONE);
            r_drop  <= w_drop_set;

            if (r_state == REQ_IDLE) begin
                r_cnt <= '0;
            end else if ((r_state == REQ_ASSERT) && (r_cnt != '1)) begin
                r_cnt <= r_cnt + TIMEOUT_W'(1);
            end

            // A new error outranks a coincident clear.
            if (w_err_set) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end

            if (w_ack) begin
                r_hitless <= fw_hitless_upd_reset;
            end
        end
    end

    assign mcu_rst_req      = r_req;
    assign rst_req_busy     = r_busy;
    assign rst_req_done     = r_done;
    assign rst_req_drop     = r_drop;
    assign rst_req_err      = r_err;
    assign last_rst_hitless = r_hitless;

endmodule

`default_nettype wire
